vga_timing_gen: RTL and testbench

- Upstream raster stage for the 640x480@60Hz display path.
- Derives a 25 MHz pixel strobe from the 100 MHz board clock.
- Generates the pixel coordinates xx/yy, the active-video flag and the hsync/vsync outputs. Sprite stages and the VGA pins consume these directly.
- All outputs are registered and advance only on pixel strobes.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/pix_strobe_div.sv | 23 ++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, coordinate width and idle sync level
package vga_timing_pkg;
   localparam int COORD_W      = 10;
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam logic SYNC_IDLE  = 1'b1;

   function automatic logic in_win(input int p, input int lo, input int len);
      return p >= lo && p < lo + len;
   endfunction
endpackage

// File: rtl/pix_strobe_div.sv
// pix_strobe_div: free-running clock divider producing a one-cycle pixel strobe
module pix_strobe_div #(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_stb
);
   localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

   logic [W-1:0] div_q, div_d;

   assign o_stb = div_q == W'(CLK_DIV - 1);

   // wrap on the strobe so the period is exactly CLK_DIV cycles
   always_comb div_d = o_stb ? '0 : div_q + W'(1);

   // divider counter register
   always_ff @(posedge i_clk) begin
      if (i_rst) div_q <= '0;
      else div_q <= div_d;
   end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480 raster counter with registered sync/active outputs; VGA_TIMING_SYNC_DELAY_EN adds a strobe-clocked delay on sync/active
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF,
   parameter int SYNC_DELAY = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   output logic       o_pix_stb,
   output logic [9:0] o_xx,
   output logic [9:0] o_yy,
   output logic       o_aactive,
   output logic       o_hsync,
   output logic       o_vsync,
   output logic       o_line_start,
   output logic       o_frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   logic       stb, h_last, v_last;
   logic [9:0] h_q, h_d, v_q, v_d, xx_q, xx_d, yy_q, yy_d;
   logic       act_q, act_d, hs_q, hs_d, vs_q, vs_d;
   logic       stb_q, stb_d, ls_q, ls_d, fs_q, fs_d;

   pix_strobe_div #(.CLK_DIV(CLK_DIV)) u_div (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .o_stb(stb)
   );

   // on each strobe present the pending position and advance it
   always_comb begin
      h_last = int'(h_q) == H_TOTAL - 1;
      v_last = int'(v_q) == V_TOTAL - 1;
      h_d    = stb ? (h_last ? '0 : h_q + 10'd1) : h_q;
      v_d    = (stb && h_last) ? (v_last ? '0 : v_q + 10'd1) : v_q;
      xx_d   = stb ? h_q : xx_q;
      yy_d   = stb ? v_q : yy_q;
      act_d  = stb ? (int'(h_q) < H_ACTIVE && int'(v_q) < V_ACTIVE) : act_q;
      hs_d   = stb ? SYNC_IDLE ^ in_win(int'(h_q), H_ACTIVE + H_FP, H_SYNC) : hs_q;
      vs_d   = stb ? SYNC_IDLE ^ in_win(int'(v_q), V_ACTIVE + V_FP, V_SYNC) : vs_q;
      stb_d  = stb;
      ls_d   = stb && h_q == '0;
      fs_d   = stb && h_q == '0 && v_q == '0;
   end

   // position and output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         h_q   <= '0;
         v_q   <= '0;
         xx_q  <= '0;
         yy_q  <= '0;
         act_q <= 1'b0;
         hs_q  <= SYNC_IDLE;
         vs_q  <= SYNC_IDLE;
         stb_q <= 1'b0;
         ls_q  <= 1'b0;
         fs_q  <= 1'b0;
      end else begin
         h_q   <= h_d;
         v_q   <= v_d;
         xx_q  <= xx_d;
         yy_q  <= yy_d;
         act_q <= act_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         stb_q <= stb_d;
         ls_q  <= ls_d;
         fs_q  <= fs_d;
      end
   end

   assign o_pix_stb     = stb_q;
   assign o_xx          = xx_q;
   assign o_yy          = yy_q;
   assign o_line_start  = ls_q;
   assign o_frame_start = fs_q;

`ifdef VGA_TIMING_SYNC_DELAY_EN
   logic [2:0] pipe_q [SYNC_DELAY];
   logic [2:0] pipe_d [SYNC_DELAY];

   // shift {active, hsync, vsync} one stage per strobe to match ROM latency
   always_comb begin
      pipe_d = pipe_q;
      if (stb) begin
         pipe_d[0] = {act_q, hs_q, vs_q};
         for (int i = 1; i < SYNC_DELAY; i++) pipe_d[i] = pipe_q[i-1];
      end
   end

   // delay-line registers, reset to idle levels
   always_ff @(posedge i_clk) begin
      if (i_rst) pipe_q <= '{default: {1'b0, SYNC_IDLE, SYNC_IDLE}};
      else pipe_q <= pipe_d;
   end

   assign {o_aactive, o_hsync, o_vsync} = pipe_q[SYNC_DELAY-1];
`else
   assign o_aactive = act_q;
   assign o_hsync   = hs_q;
   assign o_vsync   = vs_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: vector table, corner sequences and randomized resets against a raster model
module tb_vga_timing_gen;
   typedef struct packed {
      logic       stb;
      logic [9:0] xx;
      logic [9:0] yy;
      logic       act, hs, vs, ls, fs;
   } out_t;
   typedef struct {int div, ha, hfp, hsw, hbp, va, vfp, vsw, vbp, d;} tim_t;
   typedef struct {int n; logic [9:0] xx, yy; logic act, hs, vs, ls, fs;} vec_t;

`ifdef VGA_TIMING_SYNC_DELAY_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       b_stb, b_act, b_hs, b_vs, b_ls, b_fs;
   logic [9:0] b_xx, b_yy;
   logic       s_stb, s_act, s_hs, s_vs, s_ls, s_fs;
   logic [9:0] s_xx, s_yy;

   vga_timing_gen dut_b (
      .i_clk(clk), .i_rst(rst), .o_pix_stb(b_stb), .o_xx(b_xx), .o_yy(b_yy),
      .o_aactive(b_act), .o_hsync(b_hs), .o_vsync(b_vs),
      .o_line_start(b_ls), .o_frame_start(b_fs)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut_s (
      .i_clk(clk), .i_rst(rst), .o_pix_stb(s_stb), .o_xx(s_xx), .o_yy(s_yy),
      .o_aactive(s_act), .o_hsync(s_hs), .o_vsync(s_vs),
      .o_line_start(s_ls), .o_frame_start(s_fs)
   );

   int   c = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   tim_t tb_t, ts_t;

   // expected outputs after c non-reset edges: strobe k presents raster pixel k of an endless scan
   function automatic out_t model(input tim_t t, input int cyc);
      out_t o;
      int k, ht, vt, j, x, y, xs, ys;
      ht = t.ha + t.hfp + t.hsw + t.hbp;
      vt = t.va + t.vfp + t.vsw + t.vbp;
      o = '{1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      if (cyc < t.div) return o;
      k = cyc / t.div - 1;
      x = k % ht;
      y = (k / ht) % vt;
      o.stb = (cyc % t.div) == 0;
      o.xx = x[9:0];
      o.yy = y[9:0];
      o.ls = o.stb && x == 0;
      o.fs = o.ls && y == 0;
      j = k - t.d;
      if (j >= 0) begin
         xs = j % ht;
         ys = (j / ht) % vt;
         o.act = xs < t.ha && ys < t.va;
         o.hs = !(xs >= t.ha + t.hfp && xs < t.ha + t.hfp + t.hsw);
         o.vs = !(ys >= t.va + t.vfp && ys < t.va + t.vfp + t.vsw);
      end
      return o;
   endfunction

   function automatic out_t got_b();
      return {b_stb, b_xx, b_yy, b_act, b_hs, b_vs, b_ls, b_fs};
   endfunction

   function automatic out_t got_s();
      return {s_stb, s_xx, s_yy, s_act, s_hs, s_vs, s_ls, s_fs};
   endfunction

   task automatic chk(input string name, input out_t got, input out_t exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s c=%0d got stb=%0b xx=%0d yy=%0d act=%0b hs=%0b vs=%0b ls=%0b fs=%0b exp stb=%0b xx=%0d yy=%0d act=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
                    name, c, got.stb, got.xx, got.yy, got.act, got.hs, got.vs, got.ls, got.fs,
                    exp.stb, exp.xx, exp.yy, exp.act, exp.hs, exp.vs, exp.ls, exp.fs);
   endtask

   task automatic chk_i(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s c=%0d got %0d exp %0d", name, c, got, exp);
   endtask

   task automatic step(input logic r);
      rst = r;
      @(posedge clk);
      c = r ? 0 : c + 1;
      #1;
      chk("model_big", got_b(), model(tb_t, c));
      chk("model_small", got_s(), model(ts_t, c));
   endtask

   vec_t tab[14];

   initial begin
      out_t e, m;
      int t0, per;
      tb_t = '{4, 640, 16, 96, 48, 480, 10, 2, 33, D};
      ts_t = '{1, 8, 2, 3, 2, 6, 1, 2, 1, D};
      tab = '{
         '{0,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1},
         '{1,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
         '{639,  10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0},
         '{640,  10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
         '{655,  10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
         '{656,  10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
         '{751,  10'd751, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
         '{752,  10'd752, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
         '{799,  10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
         '{800,  10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
         '{1455, 10'd655, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
         '{1456, 10'd656, 10'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
         '{1599, 10'd799, 10'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
         '{1600, 10'd0,   10'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}
      };

      step(1'b1);
      step(1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0);
         chk_i("no_stb_after_rst", int'(b_stb), 0);
      end

      for (int i = 0; i < 14; i++) begin
         while (c < (tab[i].n + 1) * 4) step(1'b0);
         e = '{1'b1, tab[i].xx, tab[i].yy, tab[i].act, tab[i].hs, tab[i].vs, tab[i].ls, tab[i].fs};
`ifdef VGA_TIMING_SYNC_DELAY_EN
         m = model(tb_t, c);
         e.act = m.act;
         e.hs = m.hs;
         e.vs = m.vs;
`endif
         chk($sformatf("vec_n%0d", tab[i].n), got_b(), e);
      end

      while (c < 1901 * 4) step(1'b0);
      chk_i("pre_rst_xx", int'(b_xx), 300);
      chk_i("pre_rst_yy", int'(b_yy), 2);
      step(1'b1);
      chk("mid_rst_idle", got_b(), '{1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < 3; i++) begin
         step(1'b0);
         chk_i("post_rst_no_stb", int'(b_stb), 0);
      end
      step(1'b0);
      chk("post_rst_first", got_b(), '{1'b1, 10'd0, 10'd0, D == 0, 1'b1, 1'b1, 1'b1, 1'b1});

      t0 = -1;
      per = -1;
      for (int k = 0; k < 400 && t0 < 0; k++) begin
         step(1'b0);
         if (s_fs) t0 = c;
      end
      for (int k = 0; k < 400 && t0 >= 0 && per < 0; k++) begin
         step(1'b0);
         if (s_fs) per = c - t0;
      end
      chk_i("small_frame_period", per, 150);

      for (int it = 0; it < 25; it++) begin
         repeat ($urandom_range(1, 2500)) step(1'b0);
         repeat ($urandom_range(1, 3)) step(1'b1);
      end
      repeat (20) step(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
